// File: rtl/dmem_bridge.sv
// Bridge between the processor load/store port and a synchronous dmem.
// It adds a req/ready handshake, a configurable read latency and a small MMIO register window.
module dmem_bridge #(
  parameter int unsigned          ADDR_W      = 12,
  parameter int unsigned          DATA_W      = 32,
  parameter int unsigned          MEM_LATENCY = 1,
  parameter logic [ADDR_W-1:0]    MMIO_BASE   = 12'hFF0,
  parameter int unsigned          MMIO_REGS   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              busy,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] address_dmem,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  input  logic [DATA_W-1:0] q_dmem,
  output logic [DATA_W-1:0] global_debug_out,
  output logic [1:0]        state_dbg
);

  // Handshake: req/we/addr/wdata are sampled only in IDLE and must be held
  // until ready. ready pulses for one cycle, after busy has already dropped,
  // so a request held through the ready cycle is accepted at its closing edge.

  localparam int unsigned IDX_W = (MMIO_REGS > 1) ? $clog2(MMIO_REGS) : 1;
  localparam logic [ADDR_W:0] MMIO_LO = {1'b0, MMIO_BASE};
  localparam logic [ADDR_W:0] MMIO_HI = MMIO_LO + (ADDR_W+1)'(MMIO_REGS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MEM_RD = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state;
  logic [2:0]        cnt;
  logic              rd_pend;
  logic [DATA_W-1:0] mmio [MMIO_REGS];

  logic              mmio_hit;
  logic [IDX_W-1:0]  mmio_idx;

  assign mmio_hit         = ({1'b0, addr} >= MMIO_LO) && ({1'b0, addr} <= MMIO_HI);
  assign mmio_idx         = IDX_W'(addr - MMIO_BASE);
  assign busy             = (state != IDLE);
  assign state_dbg        = state;
  assign global_debug_out = mmio[0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= 3'd0;
      rd_pend      <= 1'b0;
      ready        <= 1'b0;
      wren         <= 1'b0;
      rdata        <= '0;
      address_dmem <= '0;
      data         <= '0;
      for (int i = 0; i < MMIO_REGS; i++) mmio[i] <= '0;
    end else begin
      ready <= 1'b0;
      wren  <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (mmio_hit) begin
              if (we) mmio[mmio_idx] <= wdata;
              else    rdata          <= mmio[mmio_idx];
              state <= DONE;
            end else begin
              address_dmem <= addr;
              if (we) begin
                data  <= wdata;
                wren  <= 1'b1;
                state <= DONE;
              end else begin
                cnt     <= 3'(MEM_LATENCY);
                rd_pend <= 1'b1;
                state   <= MEM_RD;
              end
            end
          end
        end
        MEM_RD: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) state <= DONE;
        end
        DONE: begin
          // q_dmem has been stable for a full cycle here, so capture is race-free.
          if (rd_pend) rdata <= q_dmem;
          rd_pend <= 1'b0;
          ready   <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: a latency-2 instance runs a vector table,
// a latency-3 instance covers request-while-busy handling.
module tb_dmem_bridge;
  localparam int AW = 12;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic          req2 = 1'b0, req3 = 1'b0, we = 1'b0;
  logic [AW-1:0] addr  = '0;
  logic [DW-1:0] wdata = '0;

  logic          ready2, busy2, wren2, ready3, busy3, wren3;
  logic [DW-1:0] rdata2, data2, q2, gdo2, rdata3, data3, q3, gdo3;
  logic [AW-1:0] adm2, adm3;
  logic [1:0]    st2, st3;

  dmem_bridge #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(2), .MMIO_BASE(12'hFF0), .MMIO_REGS(4)) u_dut2 (
    .clock(clock), .reset(reset), .req(req2), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready2), .busy(busy2), .rdata(rdata2), .address_dmem(adm2), .data(data2),
    .wren(wren2), .q_dmem(q2), .global_debug_out(gdo2), .state_dbg(st2)
  );

  dmem_bridge #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(3), .MMIO_BASE(12'hFF0), .MMIO_REGS(4)) u_dut3 (
    .clock(clock), .reset(reset), .req(req3), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready3), .busy(busy3), .rdata(rdata3), .address_dmem(adm3), .data(data3),
    .wren(wren3), .q_dmem(q3), .global_debug_out(gdo3), .state_dbg(st3)
  );

  // ---------------- dmem models (synchronous, latency 2 and 3) ----------------
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  logic [DW-1:0] mem2 [0:(1<<AW)-1];
  logic [DW-1:0] mem3 [0:(1<<AW)-1];
  logic [DW-1:0] p2_0, p2_1, p3_0, p3_1, p3_2;

  always @(posedge clock) begin
    if (pl_en) begin
      mem2[pl_addr] <= pl_data;
      mem3[pl_addr] <= pl_data;
    end else begin
      if (wren2) mem2[adm2] <= data2;
      if (wren3) mem3[adm3] <= data3;
    end
    p2_0 <= mem2[adm2];
    p2_1 <= p2_0;
    p3_0 <= mem3[adm3];
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end
  assign q2 = p2_1;
  assign q3 = p3_2;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ---------------- driver: one access on the latency-2 instance ----------------
  // Called at a negedge; returns at the negedge of the ready cycle with req dropped.
  task automatic acc2(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output int lat, output int wc, output logic [AW-1:0] adm_first,
                      output logic [AW-1:0] adm_last, output logic [DW-1:0] rd,
                      output logic [DW-1:0] dat);
    req2 = 1'b1; we = w; addr = a; wdata = d;
    lat = 0; wc = 0; adm_first = '0; adm_last = '0; rd = '0; dat = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (c == 1) adm_first = adm2;
      if (wren2) begin
        wc++;
        dat = data2;
      end
      if (ready2) begin
        lat      = c;
        adm_last = adm2;
        rd       = rdata2;
        break;
      end
    end
    req2 = 1'b0;
  endtask

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            lat;
    int            wc;
    logic [AW-1:0] adm;
    logic [DW-1:0] rd;
    logic [DW-1:0] gdo;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int            lat, wc, rc, bad_adm, rcyc;
    logic [AW-1:0] adm_f, adm_l;
    logic [DW-1:0] rd, dat;

    //   w     addr      wdata          lat wc adm       rdata          debug
    vecs[0] = '{1'b1, 12'h020, 32'hCAFEF00D, 2, 1, 12'h020, 32'h0,        32'h0};
    vecs[1] = '{1'b0, 12'h010, 32'h0,        4, 0, 12'h010, 32'h12345678, 32'h0};
    vecs[2] = '{1'b0, 12'h020, 32'h0,        4, 0, 12'h020, 32'hCAFEF00D, 32'h0};
    vecs[3] = '{1'b1, 12'hFF0, 32'hDEADBEEF, 2, 0, 12'h020, 32'h0,        32'hDEADBEEF};
    vecs[4] = '{1'b1, 12'hFF3, 32'h00000005, 2, 0, 12'h020, 32'h0,        32'hDEADBEEF};
    vecs[5] = '{1'b0, 12'hFF3, 32'h0,        2, 0, 12'h020, 32'h00000005, 32'hDEADBEEF};
    vecs[6] = '{1'b0, 12'hFF4, 32'h0,        4, 0, 12'hFF4, 32'hA5A50FF4, 32'hDEADBEEF};
    vecs[7] = '{1'b1, 12'h7FF, 32'h0BADCAFE, 2, 1, 12'h7FF, 32'h0,        32'hDEADBEEF};
    vecs[8] = '{1'b0, 12'h7FF, 32'h0,        4, 0, 12'h7FF, 32'h0BADCAFE, 32'hDEADBEEF};
    vecs[9] = '{1'b0, 12'hFF0, 32'h0,        2, 0, 12'h7FF, 32'hDEADBEEF, 32'hDEADBEEF};

    // ---- reset with random inputs toggling; dmem preload happens meanwhile ----
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      req2  = 1'($urandom_range(0, 1));
      req3  = 1'($urandom_range(0, 1));
      we    = 1'($urandom_range(0, 1));
      addr  = AW'($urandom_range(0, 4095));
      wdata = $urandom;
      pl_en = (c < 3);
      case (c)
        0: begin pl_addr = 12'h010; pl_data = 32'h12345678; end
        1: begin pl_addr = 12'hFF4; pl_data = 32'hA5A50FF4; end
        default: begin pl_addr = 12'h030; pl_data = 32'h33333333; end
      endcase
    end
    chk("rst_ready", {31'd0, ready2}, 32'd0);
    chk("rst_busy", {31'd0, busy2}, 32'd0);
    chk("rst_wren", {31'd0, wren2}, 32'd0);
    chk("rst_rdata", rdata2, 32'd0);
    chk("rst_address_dmem", {20'd0, adm2}, 32'd0);
    chk("rst_data", data2, 32'd0);
    chk("rst_debug_out", gdo2, 32'd0);
    chk("rst_state", {30'd0, st2}, 32'd0);
    chk("rst_state3", {30'd0, st3}, 32'd0);
    chk("rst_debug_out3", gdo3, 32'd0);
    req2 = 1'b0; req3 = 1'b0; we = 1'b0;
    reset = 1'b1;
    rc = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (ready2 || busy2) rc++;
    end
    chk("post_rst_quiet", rc, 0);

    // ---- vector table on the latency-2 instance ----
    for (int i = 0; i < 10; i++) begin
      acc2(vecs[i].w, vecs[i].a, vecs[i].d, lat, wc, adm_f, adm_l, rd, dat);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_wren_cycles", i), wc, vecs[i].wc);
      chk($sformatf("v%0d_adm_first", i), {20'd0, adm_f}, {20'd0, vecs[i].adm});
      chk($sformatf("v%0d_adm_ready", i), {20'd0, adm_l}, {20'd0, vecs[i].adm});
      if (!vecs[i].w) chk($sformatf("v%0d_rdata", i), rd, vecs[i].rd);
      if (vecs[i].wc != 0) chk($sformatf("v%0d_data", i), dat, vecs[i].d);
      chk($sformatf("v%0d_debug_out", i), gdo2, vecs[i].gdo);
      @(negedge clock);
      chk($sformatf("v%0d_ready_single", i), {31'd0, ready2}, 32'd0);
    end

    // ---- busy ignore on the latency-3 instance ----
    req3 = 1'b1; we = 1'b0; addr = 12'h030;
    rcyc = 0; bad_adm = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      if (adm3 !== 12'h030) bad_adm++;
      if (ready3) begin
        rcyc = c;
        chk("busy_rdata", rdata3, 32'h33333333);
        we = 1'b1; addr = 12'h044; wdata = 32'h00000044;
        break;
      end
      we = c[0]; addr = 12'h100 + AW'(c); wdata = 32'(c);
    end
    chk("busy_ready_cycle", rcyc, 5);
    chk("busy_adm_held", bad_adm, 0);
    @(negedge clock);
    req3 = 1'b0;
    chk("busy_next_accepted", {31'd0, busy3}, 32'd1);
    chk("busy_next_wren", {31'd0, wren3}, 32'd1);
    chk("busy_next_adm", {20'd0, adm3}, 32'h044);
    chk("busy_next_data", data3, 32'h44);
    repeat (3) @(negedge clock);

    // ---- reset one cycle after accepting a load ----
    req2 = 1'b1; we = 1'b0; addr = 12'h010;
    @(negedge clock);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_load_busy", {31'd0, busy2}, 32'd0);
    chk("rst_load_ready", {31'd0, ready2}, 32'd0);
    chk("rst_load_debug", gdo2, 32'd0);
    req2 = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    rc = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (ready2) rc++;
    end
    chk("rst_load_no_ready", rc, 0);

    // ---- reset during a store's wren cycle ----
    req2 = 1'b1; we = 1'b1; addr = 12'h050; wdata = 32'h55;
    @(posedge clock);
    #2;
    chk("rst_store_wren_before", {31'd0, wren2}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_store_wren", {31'd0, wren2}, 32'd0);
    chk("rst_store_busy", {31'd0, busy2}, 32'd0);
    req2 = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    rc = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (ready2) rc++;
    end
    chk("rst_store_no_ready", rc, 0);

    // MMIO registers must read back as zero after reset
    acc2(1'b0, 12'hFF3, 32'h0, lat, wc, adm_f, adm_l, rd, dat);
    chk("mmio_after_rst_latency", lat, 2);
    chk("mmio_after_rst_rdata", rd, 32'd0);
    chk("mmio_after_rst_debug", gdo2, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
